// File: rtl/xintf_pkg.sv
// Shared zone-2 definitions for the XINTF read responder and write decoder.
package xintf_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DRIVE,
        ST_HOLD
    } rd_state_e;

    // Zone-2 register map shared with the write-strobe decoder
    localparam logic [7:0]  ZONE2_CODE_ADDR = 8'h00;
    localparam logic [7:0]  ZONE2_FIFO_ADDR = 8'h10;
    localparam logic [15:0] ZONE2_FILL_WORD = 16'hDEAD;

endpackage

// File: rtl/xintf_sync.sv
// Three-flop synchroniser for an asynchronous DSP strobe, with edge detection.
module xintf_sync (
    input  logic clk_sys,
    input  logic rst_n,
    input  logic async_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic s1_q, s2_q, s3_q;

    // Flops come out of reset at 1 so an idle bus never looks like an edge
    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            s1_q <= 1'b1;
            s2_q <= 1'b1;
            s3_q <= 1'b1;
        end else begin
            s1_q <= async_i;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign level_o = s2_q;
    assign fall_o  = s3_q & ~s2_q;
    assign rise_o  = ~s3_q & s2_q;

endmodule

// File: rtl/xintf_rd_responder.sv
// DSP XINTF zone-2 read responder: fetches a word and drives it onto the bus.
// Optional wait-for-data timeout enabled by defining XINTF_RD_TIMEOUT_EN.
module xintf_rd_responder
    import xintf_pkg::*;
#(
    parameter int                ADDR_W    = 8,
    parameter int                DATA_W    = 16,
    parameter logic [ADDR_W-1:0] FIFO_ADDR = ADDR_W'(ZONE2_FIFO_ADDR),
    parameter int                HOLD_CYC  = 2
`ifdef XINTF_RD_TIMEOUT_EN
    ,
    parameter int                TMO_CYC   = 15,
    parameter logic [DATA_W-1:0] FILL_WORD = DATA_W'(ZONE2_FILL_WORD)
`endif
) (
    input  logic              clk_sys,
    input  logic              rst_n,
    input  logic              xzcs2_i,
    input  logic              xrd_i,
    input  logic [ADDR_W-1:0] xa_i,
    output logic [ADDR_W-1:0] rd_addr_o,
    output logic              rd_req_o,
    input  logic [DATA_W-1:0] rd_data_i,
    input  logic              rd_valid_i,
    output logic [DATA_W-1:0] xd_out_o,
    output logic              xd_oe_o,
    output logic              fifo_pop_o,
    input  logic              err_clr_i,
    output logic              err_short_o,
    output logic              err_tmo_o
);

    localparam int HOLD_W = (HOLD_CYC > 2) ? $clog2(HOLD_CYC) : 1;

    logic rd_fall, rd_rise, rd_level_unused;
    logic cs_level, cs_rise_unused, cs_fall_unused;
    logic cs_act;

    xintf_sync u_sync_rd (
        .clk_sys (clk_sys),
        .rst_n   (rst_n),
        .async_i (xrd_i),
        .level_o (rd_level_unused),
        .rise_o  (rd_rise),
        .fall_o  (rd_fall)
    );

    xintf_sync u_sync_cs (
        .clk_sys (clk_sys),
        .rst_n   (rst_n),
        .async_i (xzcs2_i),
        .level_o (cs_level),
        .rise_o  (cs_rise_unused),
        .fall_o  (cs_fall_unused)
    );

    assign cs_act = ~cs_level;

    rd_state_e         state_q, state_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              rd_req_q, rd_req_d;
    logic [DATA_W-1:0] xd_out_q, xd_out_d;
    logic              xd_oe_q, xd_oe_d;
    logic              fifo_pop_q, fifo_pop_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic              pend_q, pend_d;
    logic              err_short_q, err_short_d, short_set;

`ifdef XINTF_RD_TIMEOUT_EN
    localparam int TMO_W = (TMO_CYC > 2) ? $clog2(TMO_CYC) : 1;
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             tmo_hit_q, tmo_hit_d;
    logic             err_tmo_q, err_tmo_d, tmo_set;
`endif

    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            rd_addr_q   <= '0;
            rd_req_q    <= 1'b0;
            xd_out_q    <= '0;
            xd_oe_q     <= 1'b0;
            fifo_pop_q  <= 1'b0;
            hold_cnt_q  <= '0;
            pend_q      <= 1'b0;
            err_short_q <= 1'b0;
`ifdef XINTF_RD_TIMEOUT_EN
            tmo_cnt_q   <= '0;
            tmo_hit_q   <= 1'b0;
            err_tmo_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            rd_addr_q   <= rd_addr_d;
            rd_req_q    <= rd_req_d;
            xd_out_q    <= xd_out_d;
            xd_oe_q     <= xd_oe_d;
            fifo_pop_q  <= fifo_pop_d;
            hold_cnt_q  <= hold_cnt_d;
            pend_q      <= pend_d;
            err_short_q <= err_short_d;
`ifdef XINTF_RD_TIMEOUT_EN
            tmo_cnt_q   <= tmo_cnt_d;
            tmo_hit_q   <= tmo_hit_d;
            err_tmo_q   <= err_tmo_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        rd_addr_d  = rd_addr_q;
        rd_req_d   = 1'b0;
        xd_out_d   = xd_out_q;
        xd_oe_d    = xd_oe_q;
        fifo_pop_d = 1'b0;
        hold_cnt_d = hold_cnt_q;
        pend_d     = pend_q;
        short_set  = 1'b0;
`ifdef XINTF_RD_TIMEOUT_EN
        tmo_cnt_d  = tmo_cnt_q;
        tmo_hit_d  = tmo_hit_q;
        tmo_set    = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                // A fall seen during HOLD is started here without waiting for a new edge
                if (pend_q || (rd_fall && cs_act)) begin
                    rd_addr_d = xa_i;
                    rd_req_d  = 1'b1;
                    pend_d    = 1'b0;
                    state_d   = ST_WAIT;
`ifdef XINTF_RD_TIMEOUT_EN
                    tmo_cnt_d = '0;
                    tmo_hit_d = 1'b0;
`endif
                end
            end
            ST_WAIT: begin
                if (rd_valid_i) begin
                    xd_out_d = rd_data_i;
                    xd_oe_d  = 1'b1;
                    state_d  = ST_DRIVE;
                end else if (rd_rise) begin
                    short_set = 1'b1;
                    state_d   = ST_IDLE;
                end
`ifdef XINTF_RD_TIMEOUT_EN
                else if (tmo_cnt_q == TMO_W'(TMO_CYC - 1)) begin
                    xd_out_d  = FILL_WORD;
                    xd_oe_d   = 1'b1;
                    tmo_set   = 1'b1;
                    tmo_hit_d = 1'b1;
                    state_d   = ST_DRIVE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
`endif
            end
            ST_DRIVE: begin
                if (rd_rise) begin
                    hold_cnt_d = HOLD_W'(HOLD_CYC - 1);
                    state_d    = ST_HOLD;
`ifdef XINTF_RD_TIMEOUT_EN
                    fifo_pop_d = (rd_addr_q == FIFO_ADDR) && !tmo_hit_q;
`else
                    fifo_pop_d = (rd_addr_q == FIFO_ADDR);
`endif
                end
            end
            ST_HOLD: begin
                if (rd_fall && cs_act) begin
                    pend_d = 1'b1;
                end
                if (hold_cnt_q == '0) begin
                    xd_oe_d  = 1'b0;
                    xd_out_d = '0;
                    state_d  = ST_IDLE;
                end else begin
                    hold_cnt_d = hold_cnt_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A flag event in the same cycle as err_clr must not be lost
        err_short_d = short_set | (err_short_q & ~err_clr_i);
`ifdef XINTF_RD_TIMEOUT_EN
        err_tmo_d   = tmo_set | (err_tmo_q & ~err_clr_i);
`endif
    end

    assign rd_addr_o   = rd_addr_q;
    assign rd_req_o    = rd_req_q;
    assign xd_out_o    = xd_out_q;
    assign xd_oe_o     = xd_oe_q;
    assign fifo_pop_o  = fifo_pop_q;
    assign err_short_o = err_short_q;
`ifdef XINTF_RD_TIMEOUT_EN
    assign err_tmo_o   = err_tmo_q;
`else
    assign err_tmo_o   = 1'b0;
`endif

endmodule

// File: doc/xintf_rd_responder.md
Name: xintf_rd_responder

Overview:
- Read-side responder for the DSP external bus (XINTF zone 2); the counterpart of the write-strobe decoder that produces code_en.
- Synchronises the DSP read strobe, chip select and address into clk_sys.
- Fetches one word from the internal register/FIFO read port and drives it onto the DSP data bus through a tristate enable.
- Issues a single pop pulse when the echo-data FIFO address is read.

Parameters:
- ADDR_W, 8, width of DSP address xa and of rd_addr.
- DATA_W, 16, width of the data bus.
- FIFO_ADDR, 8'h10, address whose completed read generates fifo_pop.
- HOLD_CYC, 2, clk_sys cycles xd_oe stays high after the read strobe ends (bus hold time).
- TMO_CYC, 15, wait-for-data timeout in clk_sys cycles (optional feature only).
- FILL_WORD, 16'hDEAD, word driven on timeout.

Ports:
- clk_sys  in  1  system clock
- rst_n  in  1  reset, synchronous, active-low
- xzcs2  in  1  DSP zone-2 chip select, active-low, asynchronous
- xrd  in  1  DSP read strobe, active-low, asynchronous
- xa  in  ADDR_W  DSP address, asynchronous, stable while xrd is low
- rd_addr  out  ADDR_W  address presented to the internal read port
- rd_req  out  1  one-cycle read request to the internal read port
- rd_data  in  DATA_W  internal read data
- rd_valid  in  1  rd_data valid (one-cycle pulse, any latency at or after rd_req)
- xd_out  out  DATA_W  data to the bus pad
- xd_oe  out  1  tristate enable for the bus pad, active-high
- fifo_pop  out  1  one-cycle pulse after a completed read of FIFO_ADDR
- err_clr  in  1  clears the sticky error flags
- err_short  out  1  sticky flag: strobe ended before data was ready
- err_tmo  out  1  sticky flag: timeout occurred (tied 0 when the optional feature is out)

Behaviour:
- Reset: all outputs are 0; FSM is in IDLE; the synchroniser flops load 1 (bus idle).
- Synchronisation: xrd and xzcs2 each pass through a 3-flop chain s1→s2→s3.
  - fall = s3 & ~s2
  - rise = ~s3 & s2
  - cs_act = ~xzcs2_s2
- Start of read: fall with cs_act is registered on the second clk_sys edge after the edge that first samples xrd low.
- FSM states: IDLE, WAIT, DRIVE, HOLD.
- IDLE:
  - on fall & cs_act: rd_addr <= xa (sampled at this edge), rd_req = 1 for exactly 1 cycle, go to WAIT.
  - fall without cs_act is ignored.
- WAIT:
  - rd_valid: xd_out <= rd_data, xd_oe <= 1, go to DRIVE.
  - rise before rd_valid: set err_short, xd_oe stays 0, no fifo_pop, go to IDLE. A later rd_valid is ignored.
  - rd_valid and rise in the same cycle: rd_valid wins; go to DRIVE, then exit on the next rise.
- DRIVE:
  - xd_out is held constant.
  - on rise: go to HOLD, load the hold counter with HOLD_CYC-1.
  - fifo_pop = 1 for 1 cycle on that same transition if rd_addr == FIFO_ADDR.
- HOLD:
  - xd_oe stays 1 while the counter decrements; at 0, xd_oe <= 0, xd_out <= 0, go to IDLE.
  - A fall arriving in HOLD is latched as pending; it is serviced on entry to IDLE in the next cycle (back-to-back reads are not lost).
- The DSP wait-state configuration guarantees read strobe length ≥ 4 + read-port latency cycles. A violation is reported only through err_short.
- Sticky flags: err_clr clears them; a set event in the same cycle as err_clr wins.
- Reset mid-operation: xd_oe drops on the first reset edge; the FSM returns to IDLE and no fifo_pop is issued.

Optional Feature:
- XINTF_RD_TIMEOUT_EN defined:
  - A counter runs in WAIT. After TMO_CYC cycles without rd_valid: xd_out <= FILL_WORD, xd_oe <= 1, set err_tmo, go to DRIVE.
  - fifo_pop is suppressed for that access.
- Not defined: WAIT exits only on rd_valid or rise; err_tmo is tied to 0.

Decomposition:
- Package xintf_pkg holds:
  - FSM state enum (IDLE/WAIT/DRIVE/HOLD)
  - default FILL_WORD
  - FIFO_ADDR and the other zone-2 address constants shared with the write decoder
- Sub-module xintf_sync: 3-flop synchroniser plus rise/fall detector, instantiated for xrd and xzcs2. The write decoder can reuse it.

Test Plan:
- Read of addr 8'h04 with rd_valid 2 cycles after rd_req and rd_data 16'h1234, strobe 10 cycles → rd_req once, xd_out = 16'h1234 with xd_oe high before the strobe ends, xd_oe low HOLD_CYC cycles after rise, fifo_pop = 0.
- Read of FIFO_ADDR 8'h10, rd_data 16'hA5A5 → exactly one fifo_pop, on the DRIVE→HOLD transition.
- xrd low with xzcs2 high → no rd_req, xd_oe stays 0.
- Strobe 3 cycles with rd_valid delayed 8 cycles → err_short = 1, xd_oe never high, no fifo_pop. err_clr → err_short = 0.
- Two back-to-back reads, addresses 8'h01 then 8'h02, second fall arriving during HOLD → two rd_req pulses, rd_addr 01 then 02, both words driven in order.
- With XINTF_RD_TIMEOUT_EN, rd_valid never asserted → after 15 cycles xd_out = 16'hDEAD, err_tmo = 1, no fifo_pop even at FIFO_ADDR. Reset asserted mid-DRIVE → xd_oe = 0 on the next edge.
